// File: rtl/ace_fetch_queue.sv
// Fetch-to-decode instruction queue: compacts lane-masked fetch packets into a circular store and
// presents the oldest DEC_W instructions to decode, which may consume any prefix of them each cycle.
module ace_fetch_queue #(
   parameter int FETCH_W = 8,
   parameter int DEC_W   = 4,
   parameter int DEPTH   = 32,
   parameter int INST_W  = 32,
   parameter int PC_W    = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush_i,
   input  logic                         enq_vld_i,
   input  logic [FETCH_W-1:0]           enq_mask_i,
   input  logic [PC_W-1:0]              enq_pc_i,
   input  logic [FETCH_W*INST_W-1:0]    enq_inst_i,
   output logic                         enq_rdy_o,
   output logic [DEC_W-1:0]             deq_vld_o,
   output logic [DEC_W*INST_W-1:0]      deq_inst_o,
   output logic [DEC_W*PC_W-1:0]        deq_pc_o,
   input  logic [$clog2(DEC_W+1)-1:0]   deq_take_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         err_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   logic              r_err;
   logic [INST_W-1:0] r_inst [DEPTH];
   logic [PC_W-1:0]   r_pc   [DEPTH];

   logic              w_enq_fire;
   logic [CNT_W-1:0]  w_enq_n;
   logic [PTR_W-1:0]  w_wr_idx [FETCH_W];
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W-1:0]  w_avail;
   logic [CNT_W-1:0]  w_take_req;
   logic [CNT_W-1:0]  w_take;
   logic              w_over;

   // Outputs are forced to their idle values for the whole time reset is held.
   assign w_count    = reset ? '0 : r_count;
   assign count_o    = w_count;
   assign err_o      = r_err & ~reset;
   assign enq_rdy_o  = ~reset && ((CNT_W'(DEPTH) - r_count) >= CNT_W'(FETCH_W));
   assign w_enq_fire = enq_vld_i & enq_rdy_o & ~flush_i;

   // Lane k lands at tail plus the number of valid lanes below it.
   always_comb begin
      w_enq_n = '0;
      for (int k = 0; k < FETCH_W; k++) begin
         w_wr_idx[k] = r_tail + PTR_W'(w_enq_n);
         if (enq_mask_i[k]) w_enq_n = w_enq_n + CNT_W'(1);
      end
   end

   assign w_avail    = (r_count < CNT_W'(DEC_W)) ? r_count : CNT_W'(DEC_W);
   assign w_take_req = CNT_W'(deq_take_i);
   assign w_over     = w_take_req > w_avail;
   assign w_take     = w_over ? w_avail : w_take_req;

   always_comb begin
      deq_vld_o  = '0;
      deq_inst_o = '0;
      deq_pc_o   = '0;
      for (int j = 0; j < DEC_W; j++) begin
         if (CNT_W'(j) < w_count) begin
            deq_vld_o[j]                 = 1'b1;
            deq_inst_o[j*INST_W +: INST_W] = r_inst[r_head + PTR_W'(j)];
            deq_pc_o[j*PC_W +: PC_W]       = r_pc[r_head + PTR_W'(j)];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else if (flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq_fire) r_tail <= r_tail + PTR_W'(w_enq_n);
         r_head  <= r_head + PTR_W'(w_take);
         r_count <= r_count + (w_enq_fire ? w_enq_n : '0) - w_take;
         if (w_over) r_err <= 1'b1;
      end
   end

   // Payload storage carries no reset; validity comes from head/count alone.
   always_ff @(posedge clock) begin
      if (w_enq_fire) begin
         for (int k = 0; k < FETCH_W; k++) begin
            if (enq_mask_i[k]) begin
               r_inst[w_wr_idx[k]] <= enq_inst_i[k*INST_W +: INST_W];
               r_pc[w_wr_idx[k]]   <= enq_pc_i + PC_W'(4*k);
            end
         end
      end
   end
endmodule

// File: tb/tb_ace_fetch_queue.sv
// Directed bench for ace_fetch_queue with a queue-based scoreboard of expected instructions/PCs.
module tb_ace_fetch_queue;
   logic          clock;
   logic          reset;
   logic          flush_i;
   logic          enq_vld_i;
   logic [7:0]    enq_mask_i;
   logic [63:0]   enq_pc_i;
   logic [255:0]  enq_inst_i;
   logic          enq_rdy_o;
   logic [3:0]    deq_vld_o;
   logic [127:0]  deq_inst_o;
   logic [255:0]  deq_pc_o;
   logic [2:0]    deq_take_i;
   logic [5:0]    count_o;
   logic          err_o;

   ace_fetch_queue dut (
      .clock(clock), .reset(reset), .flush_i(flush_i),
      .enq_vld_i(enq_vld_i), .enq_mask_i(enq_mask_i), .enq_pc_i(enq_pc_i),
      .enq_inst_i(enq_inst_i), .enq_rdy_o(enq_rdy_o),
      .deq_vld_o(deq_vld_o), .deq_inst_o(deq_inst_o), .deq_pc_o(deq_pc_o),
      .deq_take_i(deq_take_i), .count_o(count_o), .err_o(err_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
   } ent_t;

   ent_t exp_q[$];
   logic exp_err;
   logic in_reset;
   int   n_assert;
   int   n_fail;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_state();
      int   sz;
      logic [3:0] ev;
      sz = exp_q.size();
      ev = '0;
      for (int j = 0; j < 4; j++) ev[j] = (j < sz);
      chk("count", 64'(count_o), 64'(sz));
      chk("rdy", 64'(enq_rdy_o), 64'(!in_reset && ((32 - sz) >= 8)));
      chk("vld", 64'(deq_vld_o), 64'(ev));
      chk("err", 64'(err_o), 64'(exp_err));
      for (int j = 0; j < 4; j++) begin
         if (j < sz) begin
            chk($sformatf("slot%0d_inst", j), 64'(deq_inst_o[j*32 +: 32]), 64'(exp_q[j].inst));
            chk($sformatf("slot%0d_pc", j), deq_pc_o[j*64 +: 64], exp_q[j].pc);
         end else begin
            chk($sformatf("slot%0d_inst_zero", j), 64'(deq_inst_o[j*32 +: 32]), 64'd0);
            chk($sformatf("slot%0d_pc_zero", j), deq_pc_o[j*64 +: 64], 64'd0);
         end
      end
   endtask

   // One clock: drive, check pre-edge outputs, clock, then apply the model's view of the edge.
   task automatic step(input logic vld, input logic [7:0] mask, input logic [63:0] pc,
                       input logic [31:0] base, input logic [2:0] take, input logic flush);
      int   sz;
      int   avail;
      int   t;
      logic acc;
      enq_vld_i  = vld;
      enq_mask_i = mask;
      enq_pc_i   = pc;
      deq_take_i = take;
      flush_i    = flush;
      for (int k = 0; k < 8; k++) enq_inst_i[k*32 +: 32] = base + 32'(k);
      #1;
      check_state();
      sz    = exp_q.size();
      avail = (sz < 4) ? sz : 4;
      t     = (int'(take) > avail) ? avail : int'(take);
      acc   = vld && ((32 - sz) >= 8) && !flush;
      @(posedge clock);
      #1;
      if (flush) begin
         exp_q.delete();
      end else begin
         if (int'(take) > avail) exp_err = 1'b1;
         for (int i = 0; i < t; i++) void'(exp_q.pop_front());
         if (acc) begin
            for (int k = 0; k < 8; k++)
               if (mask[k]) exp_q.push_back('{inst: base + 32'(k), pc: pc + 64'(4*k)});
         end
      end
      enq_vld_i  = 1'b0;
      deq_take_i = '0;
      flush_i    = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_reset = 1'b1;
      exp_q.delete();
      exp_err  = 1'b0;
      #1;
      check_state();
      @(posedge clock);
      #1;
      check_state();
      reset    = 1'b0;
      in_reset = 1'b0;
      #1;
      check_state();
   endtask

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      flush_i    = 1'b0;
      enq_vld_i  = 1'b0;
      enq_mask_i = '0;
      enq_pc_i   = '0;
      enq_inst_i = '0;
      deq_take_i = '0;
      do_reset();

      // Full packet into an empty queue.
      step(1'b1, 8'hFF, 64'h1000, 32'h100, 3'd0, 1'b0);
      check_state();
      chk("tp1_count", 64'(count_o), 64'd8);
      chk("tp1_slot0_pc", deq_pc_o[0 +: 64], 64'h1000);
      chk("tp1_slot0_inst", 64'(deq_inst_o[0 +: 32]), 64'h100);
      chk("tp1_slot3_pc", deq_pc_o[192 +: 64], 64'h100C);
      chk("tp1_slot3_inst", 64'(deq_inst_o[96 +: 32]), 64'h103);

      // Sparse mask compaction.
      step(1'b0, 8'h00, 64'h0, 32'h0, 3'd0, 1'b1);
      step(1'b1, 8'b1010_0100, 64'h2000, 32'h200, 3'd0, 1'b0);
      check_state();
      chk("tp2_vld", 64'(deq_vld_o), 64'h7);
      chk("tp2_pc0", deq_pc_o[0 +: 64], 64'h2008);
      chk("tp2_pc1", deq_pc_o[64 +: 64], 64'h2014);
      chk("tp2_pc2", deq_pc_o[128 +: 64], 64'h201C);

      // Fill to 25, held packet dropped, then enqueue with concurrent take.
      step(1'b0, 8'h00, 64'h0, 32'h0, 3'd0, 1'b1);
      step(1'b1, 8'hFF, 64'h3000, 32'h300, 3'd0, 1'b0);
      step(1'b1, 8'hFF, 64'h3100, 32'h310, 3'd0, 1'b0);
      step(1'b1, 8'hFF, 64'h3200, 32'h320, 3'd0, 1'b0);
      step(1'b1, 8'h01, 64'h3300, 32'h330, 3'd0, 1'b0);
      #1;
      chk("tp3_rdy_at_25", 64'(enq_rdy_o), 64'd0);
      step(1'b1, 8'hFF, 64'h4000, 32'h400, 3'd1, 1'b0);
      step(1'b1, 8'hFF, 64'h4000, 32'h400, 3'd4, 1'b0);
      check_state();
      chk("tp3_count28", 64'(count_o), 64'd28);

      // Move head to 30, then a packet wrapping to index 5.
      step(1'b0, 8'h00, 64'h0, 32'h0, 3'd0, 1'b1);
      step(1'b1, 8'hFF, 64'h5000, 32'h500, 3'd0, 1'b0);
      step(1'b1, 8'hFF, 64'h5020, 32'h510, 3'd0, 1'b0);
      step(1'b1, 8'hFF, 64'h5040, 32'h520, 3'd0, 1'b0);
      step(1'b1, 8'h3F, 64'h5060, 32'h530, 3'd0, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 64'h0, 32'h0, 3'd4, 1'b0);
      step(1'b0, 8'h00, 64'h0, 32'h0, 3'd2, 1'b0);
      step(1'b1, 8'h00, 64'h5F00, 32'h5F0, 3'd0, 1'b0);
      step(1'b1, 8'hFF, 64'h6000, 32'h600, 3'd0, 1'b0);
      step(1'b0, 8'h00, 64'h0, 32'h0, 3'd4, 1'b0);
      step(1'b0, 8'h00, 64'h0, 32'h0, 3'd4, 1'b0);
      check_state();

      // Flush beats enqueue and take at count 12.
      step(1'b1, 8'hFF, 64'h7000, 32'h700, 3'd0, 1'b0);
      step(1'b1, 8'h0F, 64'h7100, 32'h710, 3'd0, 1'b0);
      step(1'b1, 8'hFF, 64'h7200, 32'h720, 3'd2, 1'b1);
      check_state();
      chk("tp5_count", 64'(count_o), 64'd0);

      // Over-take sets the sticky error.
      step(1'b1, 8'h03, 64'h8000, 32'h800, 3'd0, 1'b0);
      step(1'b0, 8'h00, 64'h0, 32'h0, 3'd3, 1'b0);
      check_state();
      chk("tp6_err", 64'(err_o), 64'd1);
      step(1'b0, 8'h00, 64'h0, 32'h0, 3'd0, 1'b1);
      step(1'b1, 8'hFF, 64'h9000, 32'h900, 3'd0, 1'b0);
      check_state();
      chk("tp6_err_sticky", 64'(err_o), 64'd1);

      // Mid-operation reset discards contents and the error.
      do_reset();
      step(1'b1, 8'h81, 64'hA000, 32'hA00, 3'd0, 1'b0);
      check_state();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
